// File: rtl/mfp_ahb_arbiter.sv
// Two-master AHB arbiter: M0 (CPU) has priority, M1 (DMA) gets a forced grant
// after MAX_WAIT denied arbitration points. Ownership always rests with a master.
module mfp_ahb_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HREADY,
  input  logic        M0_HBUSREQ,
  input  logic        M1_HBUSREQ,
  input  logic        M0_HLOCK,
  input  logic        M1_HLOCK,
  input  logic [31:0] M0_HADDR,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M0_HWRITE,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M0_HWDATA,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  output logic        HMASTLOCK,
  output logic        M0_HGRANT,
  output logic        M1_HGRANT,
  output logic        HMASTER
);

  typedef enum logic {OWN0, OWN1} owner_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [7:0] MAX_W     = 8'(MAX_WAIT);

  owner_t      r_owner;
  logic        r_hmaster;
  logic        r_m0_grant;
  logic        r_m1_grant;
  logic        r_data_owner;
  logic [7:0]  r_wait_cnt;

  logic [1:0]  w_own_trans;
  logic        w_own_lock;
  logic        w_own_req;
  logic        w_arb;
  logic        w_m1_wins;

  assign w_own_trans = (r_owner == OWN1) ? M1_HTRANS  : M0_HTRANS;
  assign w_own_lock  = (r_owner == OWN1) ? M1_HLOCK   : M0_HLOCK;
  assign w_own_req   = (r_owner == OWN1) ? M1_HBUSREQ : M0_HBUSREQ;

  // Ownership may only move at a transfer boundary of an unlocked owner.
  assign w_arb = HREADY
              && ((w_own_trans == TR_IDLE) || (w_own_trans == TR_NONSEQ))
              && !(w_own_lock && w_own_req);

  assign w_m1_wins = M1_HBUSREQ && (!M0_HBUSREQ || (r_wait_cnt == MAX_W));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_owner      <= OWN0;
      r_hmaster    <= 1'b0;
      r_m0_grant   <= 1'b1;
      r_m1_grant   <= 1'b0;
      r_data_owner <= 1'b0;
      r_wait_cnt   <= '0;
    end else begin
      if (w_arb) begin
        r_owner    <= w_m1_wins ? OWN1 : OWN0;
        r_hmaster  <= w_m1_wins;
        r_m0_grant <= !w_m1_wins;
        r_m1_grant <= w_m1_wins;
      end
      if (HREADY)
        r_data_owner <= r_hmaster;
      // The counter only moves at arbitration points, so stalls and locks freeze it.
      if (!M1_HBUSREQ)
        r_wait_cnt <= '0;
      else if (w_arb) begin
        if (w_m1_wins)
          r_wait_cnt <= '0;
        else if (r_wait_cnt != MAX_W)
          r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end
  end

  assign HMASTER   = r_hmaster;
  assign M0_HGRANT = r_m0_grant;
  assign M1_HGRANT = r_m1_grant;

  assign HADDR     = r_hmaster ? M1_HADDR  : M0_HADDR;
  assign HTRANS    = r_hmaster ? M1_HTRANS : M0_HTRANS;
  assign HWRITE    = r_hmaster ? M1_HWRITE : M0_HWRITE;
  assign HSIZE     = r_hmaster ? M1_HSIZE  : M0_HSIZE;
  assign HMASTLOCK = r_hmaster ? M1_HLOCK  : M0_HLOCK;
  assign HWDATA    = r_data_owner ? M1_HWDATA : M0_HWDATA;

endmodule

// File: tb/tb_mfp_ahb_arbiter.sv
// Scoreboard bench for mfp_ahb_arbiter: directed stimulus queues expected bus
// state per cycle; a monitor on the falling edge pops and compares.
module tb_mfp_ahb_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HREADY;
  logic        M0_HBUSREQ, M1_HBUSREQ, M0_HLOCK, M1_HLOCK;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, M0_HGRANT, M1_HGRANT, HMASTER;
  logic [2:0]  HSIZE;

  mfp_ahb_arbiter #(.MAX_WAIT(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY),
    .M0_HBUSREQ(M0_HBUSREQ), .M1_HBUSREQ(M1_HBUSREQ),
    .M0_HLOCK(M0_HLOCK), .M1_HLOCK(M1_HLOCK),
    .M0_HADDR(M0_HADDR), .M1_HADDR(M1_HADDR),
    .M0_HTRANS(M0_HTRANS), .M1_HTRANS(M1_HTRANS),
    .M0_HWRITE(M0_HWRITE), .M1_HWRITE(M1_HWRITE),
    .M0_HSIZE(M0_HSIZE), .M1_HSIZE(M1_HSIZE),
    .M0_HWDATA(M0_HWDATA), .M1_HWDATA(M1_HWDATA),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HMASTLOCK(HMASTLOCK),
    .M0_HGRANT(M0_HGRANT), .M1_HGRANT(M1_HGRANT), .HMASTER(HMASTER)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       name;
    int          due;
    logic        master;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        lock;
    logic [31:0] wdata;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic m_m = 1'b0;   // expected address-phase owner
  logic m_d = 1'b0;   // expected data-phase owner

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h (cycle %0d)", nm, f, act, exp, cyc);
    end
  endtask

  // Monitor: compare every expectation that has come due.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk(e.name, "HMASTER",   {31'd0, HMASTER},   {31'd0, e.master});
        chk(e.name, "M0_HGRANT", {31'd0, M0_HGRANT}, {31'd0, !e.master});
        chk(e.name, "M1_HGRANT", {31'd0, M1_HGRANT}, {31'd0, e.master});
        chk(e.name, "HADDR",     HADDR,              e.addr);
        chk(e.name, "HTRANS",    {30'd0, HTRANS},    {30'd0, e.trans});
        chk(e.name, "HMASTLOCK", {31'd0, HMASTLOCK}, {31'd0, e.lock});
        chk(e.name, "HWDATA",    HWDATA,             e.wdata);
      end
    end
  end

  task automatic push(input string nm);
    exp_t e;
    e.name   = nm;
    e.due    = cyc;
    e.master = m_m;
    e.addr   = m_m ? M1_HADDR  : M0_HADDR;
    e.trans  = m_m ? M1_HTRANS : M0_HTRANS;
    e.lock   = m_m ? M1_HLOCK  : M0_HLOCK;
    e.wdata  = m_d ? M1_HWDATA : M0_HWDATA;
    q.push_back(e);
  endtask

  // One clock edge with the current inputs; exp is the owner expected after it.
  task automatic tick(input string nm, input logic exp);
    @(posedge HCLK);
    if (HREADY) m_d = m_m;
    m_m = exp;
    #1;
    push(nm);
    @(negedge HCLK);
    #1;
  endtask

  // Reset asserted just after an edge must take effect before the next edge.
  task automatic reset_mid(input string nm);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    m_m = 1'b0;
    m_d = 1'b0;
    #1;
    push(nm);
    @(negedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0; HREADY = 1'b1;
    M0_HBUSREQ = 0; M1_HBUSREQ = 0; M0_HLOCK = 0; M1_HLOCK = 0;
    M0_HADDR = 32'h1000_0040; M1_HADDR = 32'h2000_0080;
    M0_HWDATA = 32'hAAAA_0000; M1_HWDATA = 32'h5555_1111;
    M0_HTRANS = 2'b00; M1_HTRANS = 2'b00;
    M0_HWRITE = 1'b0; M1_HWRITE = 1'b1;
    M0_HSIZE = 3'b010; M1_HSIZE = 3'b011;

    repeat (2) @(negedge HCLK);
    #1;
    push("reset");
    @(negedge HCLK);
    #1;
    HRESETn = 1'b1;

    // Contention with a 3-cycle stall in the middle: counter must freeze.
    M0_HBUSREQ = 1; M1_HBUSREQ = 1; M0_HTRANS = 2'b10; M1_HTRANS = 2'b10;
    for (int i = 0; i < 7; i++) tick("contend", 0);
    HREADY = 0;
    repeat (3) tick("stall_m0", 0);
    HREADY = 1;
    tick("contend8", 0);
    tick("forced_m1", 1);
    tick("m0_resumes", 0);

    // M1 burst with M0 requesting; M1 drops its request mid-burst.
    M0_HBUSREQ = 0;
    tick("m1_alone", 1);
    M1_HTRANS = 2'b11; M0_HBUSREQ = 1;
    repeat (2) tick("burst", 1);
    M1_HBUSREQ = 0; M1_HTRANS = 2'b01;
    tick("burst_busy", 1);
    M1_HTRANS = 2'b11;
    tick("burst_drop", 1);
    M1_HTRANS = 2'b00;
    tick("burst_end", 0);

    // Wait states around an M1 write.
    M0_HBUSREQ = 0; M1_HBUSREQ = 1; M1_HTRANS = 2'b10; M0_HTRANS = 2'b00;
    tick("dma_grant", 1);
    HREADY = 0; M0_HBUSREQ = 1;
    repeat (3) tick("stall_hold", 1);
    HREADY = 1; M0_HBUSREQ = 0;
    tick("dma_beat", 1);
    HREADY = 0; M0_HBUSREQ = 1; M1_HTRANS = 2'b11;
    repeat (3) tick("stall_wr", 1);
    HREADY = 1; M1_HTRANS = 2'b00; M1_HBUSREQ = 0;
    tick("dma_done", 0);

    // Locked M0 sequence: no M1 grant, no counter growth.
    M0_HTRANS = 2'b10; M0_HLOCK = 1; M0_HBUSREQ = 1; M1_HBUSREQ = 1; M1_HTRANS = 2'b10;
    repeat (20) tick("locked", 0);
    M0_HLOCK = 0;
    tick("unlock_m0", 0);
    M0_HBUSREQ = 0;
    tick("unlock_m1", 1);

    // Park on M0 when nobody requests.
    M1_HTRANS = 2'b00; M1_HBUSREQ = 0;
    tick("park", 0);

    // Reset in the middle of an M1 burst.
    M1_HBUSREQ = 1; M1_HTRANS = 2'b10; M0_HTRANS = 2'b00;
    tick("pre_rst", 1);
    M1_HTRANS = 2'b11;
    tick("rst_burst", 1);
    reset_mid("async_rst");
    HRESETn = 1'b1;
    tick("post_rst", 1);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge HCLK);
    #1;
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_arbiter.md
MFP_AHB_ARBITER -- requirements
Module: mfp_ahb_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 8: number of arbitration-eligible cycles M1 may be denied before it gets forced priority; legal range 1..255.
REQ-002 HCLK  input  1  bus clock; all state changes on its rising edge.
REQ-003 HRESETn  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 HREADY  input  1  fabric ready; transfer phases advance only when 1.
REQ-005 M0_HBUSREQ, M1_HBUSREQ  input  1 each  bus request; M0 is the CPU, M1 is the DMA.
REQ-006 M0_HLOCK, M1_HLOCK  input  1 each  locked-sequence request.
REQ-007 M0_HADDR, M1_HADDR  input  32 each  address-phase address.
REQ-008 M0_HTRANS, M1_HTRANS  input  2 each  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-009 M0_HWRITE, M1_HWRITE  input  1 each; M0_HSIZE, M1_HSIZE  input  3 each.
REQ-010 M0_HWDATA, M1_HWDATA  input  32 each  data-phase write data.
REQ-011 HADDR  output  32; HTRANS  output  2; HWRITE  output  1; HSIZE  output  3  muxed address phase to the slave fabric.
REQ-012 HWDATA  output  32  muxed data-phase write data.
REQ-013 HMASTLOCK  output  1  lock of the address-phase owner.
REQ-014 M0_HGRANT, M1_HGRANT  output  1 each  registered grant, exactly one high at all times.
REQ-015 HMASTER  output  1  registered address-phase owner (0 = M0, 1 = M1).

Function
REQ-016 Owner register: states OWN0, OWN1; the design has no ownerless state. When no master requests, ownership parks on M0.
REQ-017 Arbitration point: a rising edge where HREADY=1, owner HTRANS is IDLE or NONSEQ, and the owner's HLOCK is not both asserted with its HBUSREQ.
REQ-018 Arbitration points only; winner = M1 if M1_HBUSREQ and (!M0_HBUSREQ or wait_cnt==MAX_WAIT); else M0 if M0_HBUSREQ; else M0 (park).
REQ-019 No ownership change at any other edge: HREADY=0, owner mid-burst (SEQ/BUSY), or owner locked and requesting.
REQ-020 Grant latency: a request sampled at an arbitration point updates HMASTER/HGRANT at that same edge, visible the following cycle. Outputs are never combinational from a request.
REQ-021 Address-phase mux: HADDR/HTRANS/HWRITE/HSIZE/HMASTLOCK = the signals of the master selected by HMASTER.
REQ-022 Data-phase owner register data_owner <= HMASTER on each edge with HREADY=1, held when HREADY=0; HWDATA = HWDATA of data_owner.
REQ-023 wait_cnt (8-bit): +1 on each arbitration point where M1_HBUSREQ=1 and M1 is not granted; saturates at MAX_WAIT; clears to 0 when M1 is granted or M1_HBUSREQ=0.
REQ-024 Forced M1 grant holds for one tenure only. M0 priority resumes at the next arbitration point after M1 releases.
REQ-025 Simultaneous first requests from both masters with wait_cnt<MAX_WAIT: M0 wins.
REQ-026 Owner dropping HBUSREQ mid-burst: ownership is kept until its HTRANS returns to IDLE/NONSEQ.

Reset
REQ-027 HRESETn=0 asynchronously forces HMASTER=0, data_owner=0, M0_HGRANT=1, M1_HGRANT=0, wait_cnt=0. The muxes then pass M0 signals.
REQ-028 Reset asserted mid-burst aborts the burst immediately, with no completion of the current transfer. After release, the first arbitration point follows REQ-018.

Verification
REQ-029 Reset: assert HRESETn=0 between clock edges -> HMASTER=0 and M0_HGRANT=1 before the next edge; HWDATA follows M0_HWDATA.
REQ-030 Contention: both HBUSREQ=1, HTRANS=NONSEQ, HREADY=1 -> M0 held; after 8 arbitration points M1_HGRANT=1, HMASTER=1 on the 9th edge.
REQ-031 Burst hold: M1 owns, M1_HTRANS=SEQ for 4 beats while M0 requests -> no grant change until M1_HTRANS=IDLE, then M0 granted at that edge.
REQ-032 Wait states: HREADY=0 for 3 cycles during an M1 write -> HMASTER, data_owner and wait_cnt frozen; HWDATA = M1_HWDATA throughout.
REQ-033 Lock: M0_HLOCK=1, M0_HBUSREQ=1 for 20 cycles with M1 requesting -> HMASTLOCK=1, no M1 grant, wait_cnt not incremented; M1 granted one edge after the lock drops.
REQ-034 Park: both requests deasserted while M1 owns with HTRANS=IDLE -> HMASTER=0, M0_HGRANT=1 at the next edge.
